// File: rtl/debounce_filter_pkg.sv
// Shared constants and helpers for the debounce filter.
// Defaults match the board's four push-button inputs.
package debounce_filter_pkg;

    localparam int   DEF_CHANNELS    = 4;
    localparam int   DEF_STABLE      = 4;
    localparam int   DEF_SYNC_STAGES = 2;
    localparam logic DEF_INIT_VALUE  = 1'b0;

    function automatic int cnt_width(input int stable);
        return $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: synchroniser, stability counter,
// filtered level and registered edge pulses.
module debounce_channel
    import debounce_filter_pkg::*;
#(
    parameter int   STABLE      = DEF_STABLE,
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic INIT_VALUE  = DEF_INIT_VALUE
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic sig_in,
    output logic sig_out,
    output logic rise,
    output logic fall,
    output logic pulse_d
);

    localparam int CW = cnt_width(STABLE);
    localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_d;
    logic                   out_d;
    logic                   rise_d;
    logic                   fall_d;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= {SYNC_STAGES{INIT_VALUE}};
        end else begin
            sync[0] <= sig_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    // A differing sample on the last count commits the new level.
    always_comb begin
        cnt_d  = cnt;
        out_d  = sig_out;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (!enable) begin
            cnt_d = '0;
        end else if (s == sig_out) begin
            cnt_d = '0;
        end else if (cnt == LAST) begin
            cnt_d  = '0;
            out_d  = s;
            rise_d = s;
            fall_d = ~s;
        end else begin
            cnt_d = cnt + CW'(1);
        end
    end

    assign pulse_d = rise_d | fall_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            sig_out <= INIT_VALUE;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            cnt     <= cnt_d;
            sig_out <= out_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

endmodule

// File: rtl/debounce_filter.sv
// Multi-channel debounce filter: independent lanes plus
// a shared registered "any edge" pulse.
module debounce_filter
    import debounce_filter_pkg::*;
#(
    parameter int   CHANNELS    = DEF_CHANNELS,
    parameter int   STABLE      = DEF_STABLE,
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic INIT_VALUE  = DEF_INIT_VALUE
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [CHANNELS-1:0] sig_in,
    output logic [CHANNELS-1:0] sig_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                changed
);

    logic [CHANNELS-1:0] pulse_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE      (STABLE),
            .SYNC_STAGES (SYNC_STAGES),
            .INIT_VALUE  (INIT_VALUE)
        ) u_ch (
            .clock   (clock),
            .reset_n (reset_n),
            .enable  (enable),
            .sig_in  (sig_in[i]),
            .sig_out (sig_out[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .pulse_d (pulse_d[i])
        );
    end

    // Built from next-state pulses so it lines up with rise/fall.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            changed <= 1'b0;
        end else begin
            changed <= |pulse_d;
        end
    end

endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: table vectors, corner
// sequences and random stimulus against a window model.
module tb_debounce_filter;

    localparam int CH = 4;
    localparam int ST = 4;
    localparam int SY = 2;

    logic          clock;
    logic          reset_n;
    logic          enable;
    logic [CH-1:0] sig_in;
    logic [CH-1:0] sig_out;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          changed;

    int n_cmp = 0;
    int n_bad = 0;

    debounce_filter #(
        .CHANNELS    (CH),
        .STABLE      (ST),
        .SYNC_STAGES (SY),
        .INIT_VALUE  (1'b0)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .sig_in  (sig_in),
        .sig_out (sig_out),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: a level is accepted once the most recent ST
    // enabled samples since the last accept all differ from it.
    logic [CH-1:0] m_sync [SY];
    logic [CH-1:0] m_out;
    logic [CH-1:0] m_rise;
    logic [CH-1:0] m_fall;
    logic          m_chg;
    logic [31:0]   m_hist [CH];
    int            m_nval [CH];

    task automatic model_reset();
        for (int k = 0; k < SY; k++) m_sync[k] = '0;
        m_out  = '0;
        m_rise = '0;
        m_fall = '0;
        m_chg  = 1'b0;
        for (int c = 0; c < CH; c++) begin
            m_hist[c] = '0;
            m_nval[c] = 0;
        end
    endtask

    task automatic model_step();
        logic s;
        bit ok;
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < CH; c++) begin
            if (!enable) begin
                m_nval[c] = 0;
            end else begin
                s = m_sync[SY-1][c];
                m_hist[c] = {m_hist[c][30:0], s};
                m_nval[c]++;
                ok = (m_nval[c] >= ST);
                for (int k = 0; k < ST; k++)
                    if (m_hist[c][k] == m_out[c]) ok = 0;
                if (ok) begin
                    m_out[c]  = s;
                    m_rise[c] = s;
                    m_fall[c] = ~s;
                    m_nval[c] = 0;
                end
            end
        end
        m_chg = |(m_rise | m_fall);
        for (int k = SY - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
        m_sync[0] = sig_in;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        chk("model_out", 32'(sig_out), 32'(m_out));
        chk("model_rise", 32'(rise), 32'(m_rise));
        chk("model_fall", 32'(fall), 32'(m_fall));
        chk("model_chg", 32'(changed), 32'(m_chg));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_out"}, 32'(sig_out), 32'h0);
        chk({nm, "_rise"}, 32'(rise), 32'h0);
        chk({nm, "_fall"}, 32'(fall), 32'h0);
        chk({nm, "_chg"}, 32'(changed), 32'h0);
    endtask

    typedef struct {
        logic [CH-1:0] din;
        logic          en;
        logic [CH-1:0] out;
        logic [CH-1:0] r;
        logic [CH-1:0] f;
        logic          chg;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [CH-1:0] din, logic [CH-1:0] out,
                                logic [CH-1:0] r, logic [CH-1:0] f,
                                logic chg);
        vec_t v;
        v.din = din;
        v.en  = 1'b1;
        v.out = out;
        v.r   = r;
        v.f   = f;
        v.chg = chg;
        return v;
    endfunction

    initial begin
        int found;
        reset_n = 1'b1;
        enable  = 1'b1;
        sig_in  = CH'($urandom);

        // Reset asserted mid-clock with random inputs.
        #12;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_zero("rst_async");
        repeat (2) begin
            @(posedge clock);
            #1;
            chk_zero("rst_hold");
        end
        @(negedge clock);
        reset_n = 1'b1;
        sig_in = 4'b1111;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk_zero("rst_release");
        end

        #2;
        reset_n = 1'b0;
        sig_in  = '0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;

        // Clean step on ch0: accepted at edge 6.
        for (int e = 1; e <= 5; e++)
            vt.push_back(mk(4'b0001, 4'b0000, 4'b0, 4'b0, 1'b0));
        vt.push_back(mk(4'b0001, 4'b0001, 4'b0001, 4'b0, 1'b1));
        vt.push_back(mk(4'b0001, 4'b0001, 4'b0, 4'b0, 1'b0));
        // 3-cycle glitch on ch1: rejected.
        for (int e = 1; e <= 3; e++)
            vt.push_back(mk(4'b0011, 4'b0001, 4'b0, 4'b0, 1'b0));
        for (int e = 1; e <= 4; e++)
            vt.push_back(mk(4'b0001, 4'b0001, 4'b0, 4'b0, 1'b0));
        // 4-cycle pulse on ch1: high for exactly 4 cycles.
        for (int e = 1; e <= 4; e++)
            vt.push_back(mk(4'b0011, 4'b0001, 4'b0, 4'b0, 1'b0));
        vt.push_back(mk(4'b0001, 4'b0001, 4'b0, 4'b0, 1'b0));
        vt.push_back(mk(4'b0001, 4'b0011, 4'b0010, 4'b0, 1'b1));
        for (int e = 1; e <= 3; e++)
            vt.push_back(mk(4'b0001, 4'b0011, 4'b0, 4'b0, 1'b0));
        vt.push_back(mk(4'b0001, 4'b0001, 4'b0, 4'b0010, 1'b1));
        vt.push_back(mk(4'b0001, 4'b0001, 4'b0, 4'b0, 1'b0));

        foreach (vt[i]) begin
            sig_in = vt[i].din;
            enable = vt[i].en;
            tick();
            chk($sformatf("vec%0d_out", i), 32'(sig_out), 32'(vt[i].out));
            chk($sformatf("vec%0d_rise", i), 32'(rise), 32'(vt[i].r));
            chk($sformatf("vec%0d_fall", i), 32'(fall), 32'(vt[i].f));
            chk($sformatf("vec%0d_chg", i), 32'(changed), 32'(vt[i].chg));
        end

        // Reach sig_out = 1000, then swap ch2/ch3 together.
        sig_in = 4'b1000;
        repeat (6) tick();
        chk("pre_simul_out", 32'(sig_out), 32'(4'b1000));
        sig_in = 4'b0100;
        repeat (5) tick();
        chk("simul_e5_out", 32'(sig_out), 32'(4'b1000));
        tick();
        chk("simul_out", 32'(sig_out), 32'(4'b0100));
        chk("simul_rise", 32'(rise), 32'(4'b0100));
        chk("simul_fall", 32'(fall), 32'(4'b1000));
        chk("simul_chg", 32'(changed), 32'h1);
        tick();
        chk("simul_after_chg", 32'(changed), 32'h0);

        // Enable dropped after two counts on ch0.
        sig_in = 4'b0101;
        repeat (4) tick();
        enable = 1'b0;
        repeat (3) tick();
        chk("dis_hold_out", 32'(sig_out), 32'(4'b0100));
        enable = 1'b1;
        found = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (sig_out[0] && found == 0) found = e;
        end
        chk("reenable_latency", 32'(found), 32'd4);

        // Reset pulsed while ch0 is counting down.
        sig_in = 4'b0100;
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_zero("midrst");
        @(posedge clock);
        #1;
        chk_zero("midrst_hold");
        @(negedge clock);
        reset_n = 1'b1;
        found = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (sig_out[2] && found == 0) found = e;
        end
        chk("post_rst_latency", 32'(found), 32'd6);
        chk("post_rst_ch0", 32'(sig_out[0]), 32'h0);

        // Random stimulus against the model.
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 5) == 0) sig_in[c] = ~sig_in[c];
            enable = ($urandom_range(0, 15) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/debounce_filter.md
DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001: The block SHALL have parameter CHANNELS, default 4, meaning the number of independent filtered inputs (>=1).
REQ-002: The block SHALL have parameter STABLE, default 4, meaning the consecutive synchronised samples required to accept a new level (>=1).
REQ-003: The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser depth per channel (>=1).
REQ-004: The block SHALL have parameter INIT_VALUE, default 1'b0, meaning the reset level of every channel's synchroniser and output.
REQ-005: The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006: The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007: The block SHALL have port enable, input, 1 bit: filtering enable, common to all channels.
REQ-008: The block SHALL have port sig_in, input, CHANNELS bits: raw asynchronous inputs, one per channel.
REQ-009: The block SHALL have port sig_out, output, CHANNELS bits: debounced levels.
REQ-010: The block SHALL have port rise, output, CHANNELS bits: one-cycle pulse when sig_out[i] goes 0->1.
REQ-011: The block SHALL have port fall, output, CHANNELS bits: one-cycle pulse when sig_out[i] goes 1->0.
REQ-012: The block SHALL have port changed, output, 1 bit: one-cycle pulse, OR of all rise and fall bits of the same cycle.

Function
REQ-013: Each channel SHALL pass sig_in[i] through a SYNC_STAGES-deep flop chain; the last stage is the synchronised level s[i].
REQ-014: Each channel SHALL hold a counter of width $clog2(STABLE+1), which never exceeds STABLE-1.
REQ-015: With enable=1 and s[i]==sig_out[i], the counter SHALL clear to 0.
REQ-016: With enable=1, s[i]!=sig_out[i] and counter<STABLE-1, the counter SHALL increment by 1.
REQ-017: With enable=1, s[i]!=sig_out[i] and counter==STABLE-1, sig_out[i] SHALL take s[i] on that edge and the counter SHALL clear to 0.
REQ-018: A level held on sig_in[i] SHALL appear on sig_out[i] at the (SYNC_STAGES+STABLE)-th rising edge, counting the first edge that samples it as edge 1 (6 edges with the defaults).
REQ-019: Any reversal of s[i] before the count completes SHALL discard the partial count, and sig_out[i] SHALL not change.
REQ-020: With STABLE=1, sig_out[i] SHALL follow s[i] one edge later.
REQ-021: rise[i], fall[i] and changed SHALL be registered and asserted on the same edge that sig_out[i] updates, for exactly one cycle.
REQ-022: Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each complete on their own count, and may pulse on the same cycle.
REQ-023: With enable=0, the synchronisers SHALL keep running, all counters SHALL clear, sig_out SHALL hold, and rise, fall and changed SHALL be 0.
REQ-024: After enable returns to 1, a differing level SHALL require a full STABLE-sample count.

Reset
REQ-025: While reset_n=0, asynchronously and regardless of clock, the synchroniser flops SHALL be INIT_VALUE, sig_out SHALL be {CHANNELS{INIT_VALUE}}, counters SHALL be 0, and rise, fall and changed SHALL be 0.
REQ-026: Reset asserted mid-count SHALL abort all counts; after release, any level differing from INIT_VALUE SHALL need the full latency of REQ-018.
REQ-027: Reset release SHALL not itself generate rise, fall or changed pulses.

Structure
REQ-028: A shared package SHALL hold the default parameter constants and the counter-width function (clog2 of STABLE+1).
REQ-029: Per-channel logic (synchroniser, counter, output and edge registers) SHALL be a sub-module debounce_channel, instantiated CHANNELS times by a generate loop.
REQ-030: The top level SHALL contain only the instances and the registered OR for changed.

Verification (CHANNELS=4, STABLE=4, SYNC_STAGES=2, INIT_VALUE=0)
REQ-031: Reset: hold reset_n=0 mid-clock with random sig_in -> sig_out=4'b0000, rise=fall=0, changed=0 immediately and through release.
REQ-032: Clean step: sig_in[0] 0->1 and held -> sig_out[0]=1 at edge 6, with rise[0]=1 and changed=1 for one cycle on that edge only.
REQ-033: Glitch: sig_in[1]=1 for 3 cycles then 0 -> sig_out[1] stays 0, with no pulses; a 4-cycle pulse -> sig_out[1]=1 for exactly 4 cycles, with rise then fall.
REQ-034: Simultaneous: with sig_out[3]=1, drive sig_in[2] 0->1 and sig_in[3] 1->0 on the same edge -> on one edge sig_out=4'b0100, rise=4'b0100, fall=4'b1000, changed=1.
REQ-035: Enable and mid-operation reset: drop enable after 2 counts on channel 0, then raise it -> sig_out[0] changes 4 edges after re-enable; pulse reset_n during a count -> sig_out returns to 0 and the full 6-edge latency is required after release.
